// File: rtl/button_enable_debouncer_if.sv
// Button-side bundle between the push-button source and the debouncer.
// The debouncer takes the slave view and the stimulus/button source takes the master view.
interface button_enable_debouncer_if;
  logic btn_in;
  logic enable_pulse;
  logic btn_level;
  logic release_pulse;

  modport master (
    output btn_in,
    input  enable_pulse,
    input  btn_level,
    input  release_pulse
  );

  modport slave (
    input  btn_in,
    output enable_pulse,
    output btn_level,
    output release_pulse
  );
endinterface

// File: rtl/button_enable_debouncer.sv
// Synchronises and debounces a raw push-button and emits one enable pulse per press
// (optionally auto-repeating while held), plus a debounced level and a release pulse.
module button_enable_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 5
) (
  input logic                      clock,
  input logic                      reset,
  button_enable_debouncer_if.slave bus
);

  localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM_HIGH = 2'd1,
    PRESSED  = 2'd2,
    ARM_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   btn_s;
  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic                   rep_r, rep_s;
  logic                   enable_r, enable_s;
  logic                   level_r, level_s;
  logic                   release_r, release_s;

  assign btn_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous button input.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  // Next-state, counter and output decode; rep_r selects first-delay vs period threshold.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rep_s     = rep_r;
    enable_s  = 1'b0;
    release_s = 1'b0;
    level_s   = level_r;
    case (state_r)
      IDLE: begin
        if (btn_s) begin
          state_s = ARM_HIGH;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      ARM_HIGH: begin
        if (!btn_s) begin
          state_s = IDLE;
        end else if (cnt_r == DEB_LAST) begin
          state_s  = PRESSED;
          enable_s = 1'b1;
          level_s  = 1'b1;
          cnt_s    = CNT_ZERO;
          rep_s    = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_s = ARM_LOW;
          cnt_s   = CNT_ZERO;
        end else if (REPEAT_EN != 0) begin
          if (cnt_r == (rep_r ? PER_LAST : DLY_LAST)) begin
            enable_s = 1'b1;
            cnt_s    = CNT_ZERO;
            rep_s    = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      ARM_LOW: begin
        // A return to pressed here is release bounce: restart repeat timing, no pulse.
        if (btn_s) begin
          state_s = PRESSED;
          cnt_s   = CNT_ZERO;
          rep_s   = 1'b0;
        end else if (cnt_r == DEB_LAST) begin
          state_s   = IDLE;
          level_s   = 1'b0;
          release_s = 1'b1;
          cnt_s     = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        rep_s   = 1'b0;
        level_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      rep_r     <= 1'b0;
      enable_r  <= 1'b0;
      level_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      rep_r     <= rep_s;
      enable_r  <= enable_s;
      level_r   <= level_s;
      release_r <= release_s;
    end
  end

  assign bus.enable_pulse  = enable_r;
  assign bus.btn_level     = level_r;
  assign bus.release_pulse = release_r;

endmodule
